// File: rtl/wait_scheduler.sv
// wait_scheduler: one interval timer shared by a master and a slave channel, round-robin on ties.
// Define WAIT_SCHED_FIXED_PRIO_EN to always give ties to the master.
module wait_scheduler #(
  parameter int MASTER_WAIT = 50,
  parameter int SLAVE_WAIT  = 25,
  parameter int CW          = 6
)(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m_req,
  input  logic          s_req,
  output logic          m_grant,
  output logic          s_grant,
  output logic          m_done,
  output logic          s_done,
  output logic          busy,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  localparam logic [CW-1:0] M_END = CW'(MASTER_WAIT - 1);
  localparam logic [CW-1:0] S_END = CW'(SLAVE_WAIT - 1);
  state_t        r_state, w_state;
  logic          r_owner, w_owner, r_last, w_last, w_pick_s, w_req, w_end;
  logic [CW-1:0] r_count, w_count;
`ifdef WAIT_SCHED_FIXED_PRIO_EN
  assign w_pick_s = s_req & ~m_req;
`else
  assign w_pick_s = s_req & (~m_req | ~r_last);
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_count <= w_count;
    end
  // abort beats completion: request is checked before the terminal count
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last  = r_last;
    w_count = r_count;
    w_req   = r_owner ? s_req : m_req;
    w_end   = r_count == (r_owner ? S_END : M_END);
    case (r_state)
      IDLE:
        if (m_req | s_req) begin
          w_state = COUNT;
          w_owner = w_pick_s;
          w_count = '0;
        end
      COUNT:
        if (!w_req) begin
          w_state = IDLE;
          w_count = '0;
          w_last  = r_owner;
        end else if (w_end) begin
          w_state = DONE;
          w_last  = r_owner;
        end else
          w_count = r_count + 1'b1;
      DONE: begin
        w_state = IDLE;
        w_count = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  assign m_grant = (r_state == COUNT) && !r_owner;
  assign s_grant = (r_state == COUNT) &&  r_owner;
  assign m_done  = (r_state == DONE)  && !r_owner;
  assign s_done  = (r_state == DONE)  &&  r_owner;
  assign busy    = r_state != IDLE;
  assign count   = r_count;
endmodule

// File: tb/tb_wait_scheduler.sv
// tb_wait_scheduler: directed checks of arbitration, timing, abort, reset and the period-1 corner.
module tb_wait_scheduler;
  logic       clk = 1'b0, reset_n = 1'b1;
  logic       m_req = 1'b0, s_req = 1'b0, s_req1 = 1'b0, m_req1 = 1'b0;
  logic       m_grant, s_grant, m_done, s_done, busy;
  logic [5:0] count;
  logic       m_grant1, s_grant1, m_done1, s_done1, busy1;
  logic [5:0] count1;
  int         tests = 0, fails = 0;
  always #5 clk = ~clk;
  wait_scheduler u_dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .s_req(s_req),
    .m_grant(m_grant), .s_grant(s_grant), .m_done(m_done), .s_done(s_done),
    .busy(busy), .count(count)
  );
  wait_scheduler #(.MASTER_WAIT(50), .SLAVE_WAIT(1), .CW(6)) u_p1 (
    .clk(clk), .reset_n(reset_n), .m_req(m_req1), .s_req(s_req1),
    .m_grant(m_grant1), .s_grant(s_grant1), .m_done(m_done1), .s_done(s_done1),
    .busy(busy1), .count(count1)
  );
  // packed view: {m_grant, s_grant, m_done, s_done, busy, count}
  function automatic logic [10:0] obs();
    return {m_grant, s_grant, m_done, s_done, busy, count};
  endfunction
  function automatic logic [10:0] obs1();
    return {m_grant1, s_grant1, m_done1, s_done1, busy1, count1};
  endfunction
  function automatic logic [10:0] ev(input logic mg, sg, md, sd, b, input int c);
    return {mg, sg, md, sd, b, 6'(c)};
  endfunction
  task automatic test_reset();
    logic [10:0] e;
    #1 reset_n = 1'b0;
    #2 e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL reset_async got %h want %h", obs(), e); end
    tests++; if (obs1() !== e) begin fails++; $display("FAIL reset_async_p1 got %h want %h", obs1(), e); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (obs() !== e) begin fails++; $display("FAIL reset_idle got %h want %h", obs(), e); end
  endtask
  task automatic test_single_master();
    logic [10:0] e;
    m_req = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk); e = ev(1, 0, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL single_grant j=%0d got %h want %h", j, obs(), e); end
    end
    @(negedge clk); e = ev(0, 0, 1, 0, 1, 49);
    tests++; if (obs() !== e) begin fails++; $display("FAIL single_done got %h want %h", obs(), e); end
    m_req = 1'b0;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL single_idle got %h want %h", obs(), e); end
    @(negedge clk);
    tests++; if (obs() !== e) begin fails++; $display("FAIL single_stay_idle got %h want %h", obs(), e); end
  endtask
  task automatic test_tie();
    logic [10:0] e;
    #1 reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    m_req = 1'b1; s_req = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk); e = ev(1, 0, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL tie_m j=%0d got %h want %h", j, obs(), e); end
    end
    @(negedge clk); e = ev(0, 0, 1, 0, 1, 49);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_m_done got %h want %h", obs(), e); end
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_gap1 got %h want %h", obs(), e); end
`ifdef WAIT_SCHED_FIXED_PRIO_EN
    @(negedge clk); e = ev(1, 0, 0, 0, 1, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_fixed_m_again got %h want %h", obs(), e); end
`else
    for (int j = 0; j < 25; j++) begin
      @(negedge clk); e = ev(0, 1, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL tie_s j=%0d got %h want %h", j, obs(), e); end
    end
    @(negedge clk); e = ev(0, 0, 0, 1, 1, 24);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_s_done got %h want %h", obs(), e); end
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_gap2 got %h want %h", obs(), e); end
    @(negedge clk); e = ev(1, 0, 0, 0, 1, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_m_again got %h want %h", obs(), e); end
`endif
    m_req = 1'b0; s_req = 1'b0;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL tie_abort_idle got %h want %h", obs(), e); end
  endtask
  task automatic test_abort();
    logic [10:0] e;
    s_req = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk); e = ev(0, 1, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL abort_s j=%0d got %h want %h", j, obs(), e); end
    end
    s_req = 1'b0; m_req = 1'b1;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL abort_idle got %h want %h", obs(), e); end
    s_req = 1'b1;
    @(negedge clk); e = ev(1, 0, 0, 0, 1, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL abort_m_next got %h want %h", obs(), e); end
  endtask
  task automatic test_abort_at_end();
    logic [10:0] e;
    for (int j = 1; j < 50; j++) begin
      @(negedge clk); e = ev(1, 0, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL abort_end_m j=%0d got %h want %h", j, obs(), e); end
    end
    m_req = 1'b0;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL abort_end_no_done got %h want %h", obs(), e); end
    @(negedge clk); e = ev(0, 1, 0, 0, 1, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL abort_end_s_pending got %h want %h", obs(), e); end
    s_req = 1'b0;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL abort_end_idle got %h want %h", obs(), e); end
  endtask
  task automatic test_reset_mid();
    logic [10:0] e;
    m_req = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk); e = ev(1, 0, 0, 0, 1, j);
      tests++; if (obs() !== e) begin fails++; $display("FAIL rst_mid_m j=%0d got %h want %h", j, obs(), e); end
    end
    #2 reset_n = 1'b0;
    #1 e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL rst_mid_async got %h want %h", obs(), e); end
    s_req = 1'b1;
    @(negedge clk);
    tests++; if (obs() !== e) begin fails++; $display("FAIL rst_mid_held got %h want %h", obs(), e); end
    reset_n = 1'b1;
    @(negedge clk); e = ev(1, 0, 0, 0, 1, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL rst_mid_m_first got %h want %h", obs(), e); end
    m_req = 1'b0; s_req = 1'b0;
    @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
    tests++; if (obs() !== e) begin fails++; $display("FAIL rst_mid_idle got %h want %h", obs(), e); end
  endtask
  task automatic test_period1();
    logic [10:0] e;
    s_req1 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); e = ev(0, 1, 0, 0, 1, 0);
      tests++; if (obs1() !== e) begin fails++; $display("FAIL p1_grant r=%0d got %h want %h", r, obs1(), e); end
      @(negedge clk); e = ev(0, 0, 0, 1, 1, 0);
      tests++; if (obs1() !== e) begin fails++; $display("FAIL p1_done r=%0d got %h want %h", r, obs1(), e); end
      @(negedge clk); e = ev(0, 0, 0, 0, 0, 0);
      tests++; if (obs1() !== e) begin fails++; $display("FAIL p1_idle r=%0d got %h want %h", r, obs1(), e); end
    end
    s_req1 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single_master();
    test_tie();
    test_abort();
    test_abort_at_end();
    test_reset_mid();
    test_period1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
